fifo_unpack: RTL and testbench



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_unpack.sv | 105 ++++++++++
 tb/tb_fifo_unpack.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo block and its read-side stages:
// default word/beat widths, the unpacker state encoding and a clog2 helper.
package fifo_pkg;

    localparam int FIFO_D_SIZE = 32;
    localparam int FIFO_O_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } unpack_state_t;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_unpack.sv
// Read-side unpacker for the fifo block. Pulls one D_SIZE word at a time
// from the FIFO and re-emits it as N_BEATS narrow beats on a valid/ready
// stream, least significant slice first. The next word is requested in the
// same cycle as the final beat's handshake, so a busy stream loses only one
// cycle (the FETCH bubble) per word.
module fifo_unpack
    import fifo_pkg::*;
#(
    parameter int D_SIZE = FIFO_D_SIZE,
    parameter int O_SIZE = FIFO_O_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_empty,
    output logic              rd_en,
    input  logic [D_SIZE-1:0] d_in,
    output logic [O_SIZE-1:0] o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              busy
);

    localparam int N_BEATS = D_SIZE / O_SIZE;
    localparam int B_W     = (clog2(N_BEATS) > 1) ? clog2(N_BEATS) : 1;

    localparam logic [B_W-1:0] LAST_BEAT = B_W'(N_BEATS - 1);
    localparam logic [B_W-1:0] PRE_LAST  = B_W'(N_BEATS - 2);

    unpack_state_t     state;
    logic [D_SIZE-1:0] shreg;
    logic [B_W-1:0]    beat;

    logic accept;
    logic last_accept;

    assign accept      = (state == SEND) && o_valid && o_ready;
    assign last_accept = accept && (beat == LAST_BEAT);

    assign o_data = shreg[O_SIZE-1:0];
    assign busy   = (state != IDLE);

    // FIFO read request: only from IDLE or on the final beat's handshake,
    // never while the FIFO is empty, and forced low while reset is held so
    // the request drops without waiting for a clock edge.
    always_comb begin
        rd_en = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    rd_en = !f_empty;
                SEND:    rd_en = last_accept && !f_empty;
                default: rd_en = 1'b0;
            endcase
        end
    end

    // Sequencer: fetch a word, walk its slices out, then either prefetch the
    // next word or fall back to IDLE when the FIFO has run dry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            beat    <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!f_empty) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    shreg   <= d_in;
                    beat    <= '0;
                    o_valid <= 1'b1;
                    o_last  <= (LAST_BEAT == '0);
                    state   <= SEND;
                end

                SEND: begin
                    if (accept) begin
                        if (beat == LAST_BEAT) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            state   <= f_empty ? IDLE : FETCH;
                        end else begin
                            shreg  <= shreg >> O_SIZE;
                            beat   <= beat + B_W'(1);
                            o_last <= (beat == PRE_LAST);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_unpack.sv
// Testbench for fifo_unpack: a behavioural FIFO with a registered read
// port feeds the unpacker, and a byte scoreboard checks every accepted beat.
module tb_fifo_unpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_empty;
    logic        rd_en;
    logic [31:0] fifo_dout;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_ready;
    logic        o_last;
    logic        busy;

    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr = 8'd0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q [$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    int         cyc, beat_cnt, rd_cnt, gap_cnt, pending, last_hs_cyc;
    bit         seen_valid, last_hs;

    typedef struct packed {
        bit          push;
        logic [31:0] word;
        bit          ready;
        bit          e_rd;
        bit          e_valid;
        logic [7:0]  e_data;
        bit          e_last;
        bit          e_busy;
    } vec_t;

    vec_t vecs [18];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    assign f_empty = (wr_ptr == rd_ptr);

    // FIFO read port: data appears on fifo_dout the edge after an accepted read.
    always @(posedge clk) begin
        if (rd_en && !f_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    fifo_unpack #(.D_SIZE(32), .O_SIZE(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_empty (f_empty),
        .rd_en   (rd_en),
        .d_in    (fifo_dout),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_last  (o_last),
        .busy    (busy)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3), w[i*8 +: 8]});
        end
    endtask

    task automatic reset_counters();
        cyc         = 0;
        beat_cnt    = 0;
        rd_cnt      = 0;
        gap_cnt     = 0;
        pending     = 0;
        seen_valid  = 1'b0;
        last_hs     = 1'b0;
        last_hs_cyc = -1;
    endtask

    // One clock cycle: drive inputs after the falling edge, sample the DUT
    // 1 ns later and run the scoreboard and protocol checks for that cycle.
    task automatic apply_stimulus(input bit ready, input bit push, input logic [31:0] word);
        logic [8:0] e;
        @(negedge clk);
        if (push) push_word(word);
        o_ready = ready;
        #1;
        cyc++;
        if (prev_stall) begin
            check_output("stall_valid", 32'(o_valid), 32'd1);
            check_output("stall_data", 32'(o_data), 32'(prev_data));
            check_output("stall_last", 32'(o_last), 32'(prev_last));
        end
        if (rd_en) begin
            rd_cnt++;
            check_output("rd_en_while_empty", 32'(f_empty), 32'd0);
            if (o_valid) check_output("prefetch_on_last_hs", 32'(o_last && o_ready), 32'd1);
        end
        if (o_valid) begin
            seen_valid = 1'b1;
            gap_cnt    = gap_cnt + pending;
            pending    = 0;
        end else if (seen_valid) begin
            pending++;
        end
        if (o_valid && o_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", o_data);
            end else begin
                e = exp_q.pop_front();
                check_output("beat_data", 32'(o_data), 32'(e[7:0]));
                check_output("beat_last", 32'(o_last), 32'(e[8]));
            end
            if (o_last) begin
                last_hs     = 1'b1;
                last_hs_cyc = cyc;
            end
        end
        prev_stall = o_valid && !o_ready;
        prev_data  = o_data;
        prev_last  = o_last;
    endtask

    // Hard stop in case something wedges the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence.
    initial begin
        rst_n   = 1'b0;
        o_ready = 1'b0;
        wr_ptr  = 8'd0;

        vecs[0]  = '{1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hDD, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h87654321, 1'b0, 1'b1, 1'b0, 8'hDD, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hDD, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h43, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h65, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h87, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h87, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h87, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_o_valid", 32'(o_valid), 32'd0);
        check_output("reset_o_last", 32'(o_last), 32'd0);
        check_output("reset_o_data", 32'(o_data), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_rd_en", 32'(rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("post_reset_rd_en_empty", 32'(rd_en), 32'd0);
        check_output("post_reset_busy", 32'(busy), 32'd0);

        // Single word, then a second word under backpressure
        reset_counters();
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].ready, vecs[i].push, vecs[i].word);
            check_output($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(vecs[i].e_rd));
            check_output($sformatf("vec%0d_o_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            check_output($sformatf("vec%0d_o_data", i), 32'(o_data), 32'(vecs[i].e_data));
            check_output($sformatf("vec%0d_o_last", i), 32'(o_last), 32'(vecs[i].e_last));
            check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end
        check_output("vec_rd_pulses", 32'(rd_cnt), 32'd2);

        // Back-to-back streaming of four queued words
        reset_counters();
        apply_stimulus(1'b1, 1'b1, 32'h03020100);
        push_word(32'h13121110);
        push_word(32'h23222120);
        push_word(32'h33323130);
        for (int i = 0; i < 21; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("stream_beats", 32'(beat_cnt), 32'd16);
        check_output("stream_last_cycle", 32'(last_hs_cyc), 32'd21);
        check_output("stream_rd_count", 32'(rd_cnt), 32'd4);
        check_output("stream_bubbles", 32'(gap_cnt), 32'd3);
        check_output("stream_drained", 32'(exp_q.size()), 32'd0);
        check_output("stream_end_busy", 32'(busy), 32'd0);

        // Random backpressure over 64 words
        reset_counters();
        apply_stimulus(bit'($urandom_range(0, 9) < 3), 1'b1, $urandom);
        for (int i = 1; i < 64; i++) push_word($urandom);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            apply_stimulus(bit'($urandom_range(0, 9) < 3), 1'b0, 32'h0);
        end
        check_output("bp_beats", 32'(beat_cnt), 32'd256);
        check_output("bp_drained", 32'(exp_q.size()), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("bp_end_busy", 32'(busy), 32'd0);

        // FIFO empty at the word boundary, next word arrives 3 cycles later
        reset_counters();
        apply_stimulus(1'b1, 1'b1, 32'hA5A4A3A2);
        for (int i = 0; i < 12 && !last_hs; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("boundary_first_done", 32'(last_hs), 32'd1);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("boundary_idle_busy", 32'(busy), 32'd0);
        check_output("boundary_idle_rd_en", 32'(rd_en), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 32'h5A4B3C2D);
        check_output("boundary_rd_en", 32'(rd_en), 32'd1);
        check_output("boundary_push_busy", 32'(busy), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("boundary_fetch_valid", 32'(o_valid), 32'd0);
        check_output("boundary_fetch_busy", 32'(busy), 32'd1);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("boundary_first_valid", 32'(o_valid), 32'd1);
        check_output("boundary_first_data", 32'(o_data), 32'h2D);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("boundary_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset after the second beat of a word
        reset_counters();
        apply_stimulus(1'b1, 1'b1, 32'h44332211);
        for (int i = 0; i < 10 && beat_cnt < 2; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("areset_two_beats", 32'(beat_cnt), 32'd2);
        @(negedge clk);
        o_ready = 1'b0;
        #1;
        check_output("areset_pre_valid", 32'(o_valid), 32'd1);
        check_output("areset_pre_data", 32'(o_data), 32'h33);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("areset_o_valid", 32'(o_valid), 32'd0);
        check_output("areset_busy", 32'(busy), 32'd0);
        check_output("areset_rd_en", 32'(rd_en), 32'd0);
        check_output("areset_o_last", 32'(o_last), 32'd0);
        check_output("areset_o_data", 32'(o_data), 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        push_word(32'h0D0C0B0A);
        #1;
        check_output("areset_rd_en_held", 32'(rd_en), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        o_ready = 1'b1;
        #1;
        check_output("areset_release_rd_en", 32'(rd_en), 32'd1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("areset_new_word_drained", 32'(exp_q.size()), 32'd0);

        // Long idle with the FIFO empty
        apply_stimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            check_output("idle_rd_en", 32'(rd_en), 32'd0);
            check_output("idle_o_valid", 32'(o_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
